// File: rtl/sonar_uc.sv
// sonar_uc: control unit for the sonar sweep.
// Sequences the datapath through measure / transmit / rotate steps:
// a measurement request goes to the HC-SR04 interface, the serial frame is
// awaited under a 2 s timeout, then the servo steps and a 1 s settling
// interval is timed.
//
// Ports:
//   clock          system clock
//   reset          synchronous, active-high; returns to INICIAL
//   ligar          level, 1 = continuous sweep
//   mensurar       one-cycle pulse, single measurement (only when ligar=0)
//   pronto         one-cycle pulse, serial frame finished
//   fim_2s/fim_1s  datapath timer terminal counts
//   zera           one-cycle clear of timers and position counter
//   zera_timer     one-cycle clear of both timers
//   medir          one-cycle start pulse to the sensor interface
//   conta_timeout  level, enables the 2 s timer
//   gira           one-cycle step pulse to the position counter
//   conta_giro     level, enables the 1 s timer
//   fim_varredura  one-cycle pulse when the position tracker wraps
//   erro           sticky timeout flag
//   num_erros      saturating timeout count
//   db_estado      current state code
module sonar_uc #(
    parameter int unsigned N_POSICOES = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ligar,
    input  logic       mensurar,
    input  logic       pronto,
    input  logic       fim_2s,
    input  logic       fim_1s,
    output logic       zera,
    output logic       zera_timer,
    output logic       medir,
    output logic       conta_timeout,
    output logic       gira,
    output logic       conta_giro,
    output logic       fim_varredura,
    output logic       erro,
    output logic [3:0] num_erros,
    output logic [3:0] db_estado
);

    localparam int unsigned PW = (N_POSICOES > 1) ? $clog2(N_POSICOES) : 1;
    localparam logic [PW-1:0] POS_MAX = PW'(N_POSICOES - 1);

    typedef enum logic [3:0] {
        INICIAL     = 4'd0,
        PREPARA     = 4'd1,
        UNICA       = 4'd2,
        MEDE        = 4'd3,
        AGUARDA     = 4'd4,
        TIMEOUT     = 4'd5,
        POS_MEDIDA  = 4'd6,
        GIRA        = 4'd7,
        ESPERA_GIRO = 4'd8
    } estado_t;

    estado_t       r_estado;
    estado_t       w_prox;
    logic          r_modo_unico;
    logic [PW-1:0] r_pos;

    logic          r_zera;
    logic          r_zera_timer;
    logic          r_medir;
    logic          r_conta_timeout;
    logic          r_gira;
    logic          r_conta_giro;
    logic          r_fim_varredura;
    logic          r_erro;
    logic [3:0]    r_num_erros;

    always_comb begin
        w_prox = INICIAL;
        case (r_estado)
            INICIAL: begin
                if (ligar)
                    w_prox = PREPARA;
                else if (mensurar)
                    w_prox = UNICA;
                else
                    w_prox = INICIAL;
            end
            PREPARA:     w_prox = MEDE;
            UNICA:       w_prox = MEDE;
            MEDE:        w_prox = AGUARDA;
            AGUARDA: begin
                // pronto has priority over a coincident timeout
                if (pronto)
                    w_prox = POS_MEDIDA;
                else if (fim_2s)
                    w_prox = TIMEOUT;
                else
                    w_prox = AGUARDA;
            end
            TIMEOUT:     w_prox = POS_MEDIDA;
            POS_MEDIDA:  w_prox = r_modo_unico ? INICIAL : GIRA;
            GIRA:        w_prox = ESPERA_GIRO;
            ESPERA_GIRO: begin
                if (fim_1s)
                    w_prox = ligar ? MEDE : INICIAL;
                else
                    w_prox = ESPERA_GIRO;
            end
            default:     w_prox = INICIAL;
        endcase
    end

    // Strobes are registered from the next-state decode so they line up
    // exactly with the state they belong to.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_estado        <= INICIAL;
            r_modo_unico    <= 1'b0;
            r_pos           <= '0;
            r_zera          <= 1'b0;
            r_zera_timer    <= 1'b0;
            r_medir         <= 1'b0;
            r_conta_timeout <= 1'b0;
            r_gira          <= 1'b0;
            r_conta_giro    <= 1'b0;
            r_fim_varredura <= 1'b0;
            r_erro          <= 1'b0;
            r_num_erros     <= '0;
        end else begin
            r_estado        <= w_prox;
            r_zera          <= (w_prox == PREPARA);
            r_zera_timer    <= (w_prox == UNICA) || (w_prox == MEDE) || (w_prox == GIRA);
            r_medir         <= (w_prox == MEDE);
            r_conta_timeout <= (w_prox == AGUARDA);
            r_gira          <= (w_prox == GIRA);
            r_conta_giro    <= (w_prox == ESPERA_GIRO);
            r_fim_varredura <= 1'b0;

            case (r_estado)
                UNICA:      r_modo_unico <= 1'b1;
                TIMEOUT: begin
                    r_erro <= 1'b1;
                    if (r_num_erros != 4'hF)
                        r_num_erros <= r_num_erros + 4'd1;
                end
                POS_MEDIDA: r_modo_unico <= 1'b0;
                GIRA: begin
                    if (r_pos == POS_MAX) begin
                        r_pos           <= '0;
                        r_fim_varredura <= 1'b1;
                    end else begin
                        r_pos <= r_pos + 1'b1;
                    end
                end
                default: ;
            endcase

            // Entering PREPARA starts a fresh sweep; num_erros is kept.
            if (w_prox == PREPARA) begin
                r_erro <= 1'b0;
                r_pos  <= '0;
            end
        end
    end

    assign zera          = r_zera;
    assign zera_timer    = r_zera_timer;
    assign medir         = r_medir;
    assign conta_timeout = r_conta_timeout;
    assign gira          = r_gira;
    assign conta_giro    = r_conta_giro;
    assign fim_varredura = r_fim_varredura;
    assign erro          = r_erro;
    assign num_erros     = r_num_erros;
    assign db_estado     = r_estado;

endmodule

// File: tb/tb_sonar_uc.sv
// tb_sonar_uc: directed bench for sonar_uc with hand-computed expectations.
module tb_sonar_uc;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       ligar = 1'b0;
    logic       mensurar = 1'b0;
    logic       pronto = 1'b0;
    logic       fim_2s = 1'b0;
    logic       fim_1s = 1'b0;
    logic       zera, zera_timer, medir, conta_timeout, gira, conta_giro;
    logic       fim_varredura, erro;
    logic [3:0] num_erros, db_estado;

    sonar_uc #(.N_POSICOES(8)) dut (
        .clock(clock), .reset(reset), .ligar(ligar), .mensurar(mensurar),
        .pronto(pronto), .fim_2s(fim_2s), .fim_1s(fim_1s),
        .zera(zera), .zera_timer(zera_timer), .medir(medir),
        .conta_timeout(conta_timeout), .gira(gira), .conta_giro(conta_giro),
        .fim_varredura(fim_varredura), .erro(erro), .num_erros(num_erros),
        .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    int unsigned cnt_gira = 0, cnt_fv = 0, cnt_medir = 0, n_wide = 0;
    int unsigned fv_at_gira = 0;
    logic        fv_after_gira = 1'b0;
    logic        p_zera = 1'b0, p_medir = 1'b0, p_gira = 1'b0, p_fv = 1'b0;
    logic [31:0] hist = '0;
    logic [3:0]  last_st = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [10:0] all_outs();
        return {zera, zera_timer, medir, conta_timeout, gira, conta_giro,
                fim_varredura, erro, num_erros};
    endfunction

    // Advance one cycle and sample just after the edge.
    task automatic tick();
        @(posedge clock);
        #1;
        if (gira) cnt_gira++;
        if (medir) cnt_medir++;
        if (fim_varredura) begin
            cnt_fv++;
            fv_at_gira    = cnt_gira;
            fv_after_gira = p_gira;
        end
        if ((zera && p_zera) || (medir && p_medir) || (gira && p_gira) ||
            (fim_varredura && p_fv))
            n_wide++;
        p_zera = zera; p_medir = medir; p_gira = gira; p_fv = fim_varredura;
        if (db_estado != last_st) begin
            hist    = {hist[27:0], db_estado};
            last_st = db_estado;
        end
    endtask

    // From MEDE: normal measure, rotate, settle, back to MEDE.
    task automatic do_loop();
        tick();
        pronto = 1'b1; tick(); pronto = 1'b0;
        tick();
        tick();
        fim_1s = 1'b1; tick(); fim_1s = 1'b0;
        chk("loop_end_state", 32'(db_estado), 32'd3);
    endtask

    // From MEDE: timeout path, rotate, settle, back to MEDE.
    task automatic do_timeout_loop();
        tick();
        fim_2s = 1'b1; tick(); fim_2s = 1'b0;
        tick();
        tick();
        tick();
        fim_1s = 1'b1; tick(); fim_1s = 1'b0;
    endtask

    int unsigned m0, g0;

    initial begin
        // reset
        tick(); tick();
        chk("reset_state", 32'(db_estado), 32'd0);
        chk("reset_outs", 32'(all_outs()), 32'd0);
        reset = 1'b0;
        tick();
        hist = '0; last_st = db_estado;

        // first sweep loop
        ligar = 1'b1;
        tick();
        chk("prepara_state", 32'(db_estado), 32'd1);
        chk("prepara_zera", 32'(zera), 32'd1);
        tick();
        chk("mede_medir", 32'(medir), 32'd1);
        chk("mede_zt", 32'(zera_timer), 32'd1);
        tick();
        chk("aguarda_ct", 32'(conta_timeout), 32'd1);
        tick(); tick(); tick();
        chk("aguarda_hold", 32'(db_estado), 32'd4);
        pronto = 1'b1; tick(); pronto = 1'b0;
        chk("pos_medida", 32'(db_estado), 32'd6);
        tick();
        chk("gira_pulse", 32'(gira), 32'd1);
        tick();
        chk("conta_giro", 32'(conta_giro), 32'd1);
        for (int i = 0; i < 9; i++) tick();
        chk("espera_hold", 32'(db_estado), 32'd8);
        fim_1s = 1'b1; tick(); fim_1s = 1'b0;
        chk("remede_medir", 32'(medir), 32'd1);
        chk("seq_sweep", hist, 32'h0134_6783);
        chk("sweep_erro", 32'(erro), 32'd0);
        chk("sweep_gira_cnt", cnt_gira, 32'd1);

        // 8 more loops: wrap on the 8th gira only
        for (int i = 0; i < 8; i++) do_loop();
        chk("gira_total", cnt_gira, 32'd9);
        chk("fv_count", cnt_fv, 32'd1);
        chk("fv_at_8th", fv_at_gira, 32'd8);
        chk("fv_after_gira", 32'(fv_after_gira), 32'd1);

        // first timeout
        tick();
        fim_2s = 1'b1; tick(); fim_2s = 1'b0;
        chk("timeout_state", 32'(db_estado), 32'd5);
        chk("timeout_erro_pre", 32'(erro), 32'd0);
        tick();
        chk("timeout_erro", 32'(erro), 32'd1);
        chk("timeout_nerr1", 32'(num_erros), 32'd1);
        chk("timeout_pos", 32'(db_estado), 32'd6);
        tick();
        chk("timeout_gira", 32'(gira), 32'd1);
        tick();
        fim_1s = 1'b1; tick(); fim_1s = 1'b0;

        // 16 more timeouts: saturation
        for (int i = 0; i < 16; i++) do_timeout_loop();
        chk("nerr_sat", 32'(num_erros), 32'd15);
        chk("erro_sticky", 32'(erro), 32'd1);

        // drop ligar during AGUARDA
        tick();
        ligar = 1'b0;
        tick(); tick();
        chk("drop_aguarda", 32'(db_estado), 32'd4);
        pronto = 1'b1; tick(); pronto = 1'b0;
        tick();
        chk("drop_gira", 32'(gira), 32'd1);
        tick();
        fim_1s = 1'b1; tick(); fim_1s = 1'b0;
        chk("drop_inicial", 32'(db_estado), 32'd0);
        m0 = cnt_medir;
        for (int i = 0; i < 5; i++) tick();
        chk("drop_no_medir", cnt_medir, m0);
        chk("drop_idle", 32'(db_estado), 32'd0);

        // single measurement
        hist = '0; last_st = db_estado;
        g0 = cnt_gira;
        mensurar = 1'b1; tick(); mensurar = 1'b0;
        chk("unica_state", 32'(db_estado), 32'd2);
        chk("unica_zt", 32'(zera_timer), 32'd1);
        tick(); tick();
        pronto = 1'b1; tick(); pronto = 1'b0;
        tick();
        chk("seq_unica", hist, 32'h0002_3460);
        chk("unica_no_gira", cnt_gira, g0);

        // mensurar ignored when ligar=1; PREPARA clears erro, keeps count
        ligar = 1'b1; mensurar = 1'b1; tick(); mensurar = 1'b0;
        chk("ligar_wins", 32'(db_estado), 32'd1);
        chk("prepara_erro", 32'(erro), 32'd0);
        chk("prepara_nerr", 32'(num_erros), 32'd15);
        tick(); tick();
        pronto = 1'b1; fim_2s = 1'b1; tick(); pronto = 1'b0; fim_2s = 1'b0;
        chk("tie_state", 32'(db_estado), 32'd6);
        chk("tie_erro", 32'(erro), 32'd0);
        tick(); tick();
        chk("pre_reset_state", 32'(db_estado), 32'd8);

        // reset from ESPERA_GIRO
        reset = 1'b1; tick(); reset = 1'b0;
        chk("rst_state", 32'(db_estado), 32'd0);
        chk("rst_outs", 32'(all_outs()), 32'd0);

        chk("strobe_width", n_wide, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
